// File: rtl/mips_pkg.sv
// Shared types and opcode constants for the bus-based MIPS core.
// Used by the sequencer and the control decoder.
package mips_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_LOAD      = 3'd1,
        S_MEM       = 3'd2,
        S_LOAD_DATA = 3'd3,
        S_EXEC      = 3'd4,
        S_HALT      = 3'd5
    } cpu_state_t;

    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] OP_LB      = 6'd32;
    localparam logic [5:0] OP_LH      = 6'd33;
    localparam logic [5:0] OP_LWL     = 6'd34;
    localparam logic [5:0] OP_LW      = 6'd35;
    localparam logic [5:0] OP_LBU     = 6'd36;
    localparam logic [5:0] OP_LHU     = 6'd37;
    localparam logic [5:0] OP_LWR     = 6'd38;
    localparam logic [5:0] OP_SB      = 6'd40;
    localparam logic [5:0] OP_SH      = 6'd41;
    localparam logic [5:0] OP_SW      = 6'd43;

    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;

    function automatic logic is_load_op(input logic [5:0] op);
        return (op >= OP_LB) && (op <= OP_LWR);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return is_load_op(op) || (op == OP_SB) ||
               (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle state sequencer: owns the CPU state register and strobes.
// Optional EXEC hold on multiply/divide busy: CPU_SEQ_MD_STALL_EN.
module cpu_sequencer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic [5:0]  instr_opcode,
    input  logic [5:0]  opcode,
    input  logic        md_busy,
    input  logic [31:0] next_pc,
    output logic [2:0]  state,
    output logic        ir_wren,
    output logic        data_wren,
    output logic        pc_wren,
    output logic        stall,
    output logic        active
);

    cpu_state_t cur;
    cpu_state_t nxt;
    logic       md_hold;

`ifdef CPU_SEQ_MD_STALL_EN
    // Busy covers both the hi/lo write hold and MFHI/MFLO reads.
    assign md_hold = md_busy;
`else
    logic unused_md;
    assign md_hold   = 1'b0;
    assign unused_md = md_busy;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cur    <= S_FETCH;
            active <= 1'b1;
        end else begin
            cur    <= nxt;
            active <= (nxt != S_HALT);
        end
    end

    always_comb begin
        nxt = cur;
        if (reset) begin
            nxt = S_FETCH;
        end else begin
            unique case (cur)
                S_FETCH: nxt = S_LOAD;
                S_LOAD: begin
                    if (!waitrequest)
                        nxt = is_mem_op(instr_opcode) ? S_MEM : S_EXEC;
                end
                S_MEM: begin
                    if (!waitrequest)
                        nxt = is_load_op(opcode) ? S_LOAD_DATA : S_EXEC;
                end
                S_LOAD_DATA: nxt = S_EXEC;
                S_EXEC: begin
                    if (!md_hold)
                        nxt = (next_pc == 32'd0) ? S_HALT : S_FETCH;
                end
                S_HALT: nxt = S_HALT;
                default: nxt = S_FETCH;
            endcase
        end
    end

    // Reset suppresses every strobe so an abandoned instruction writes nothing.
    always_comb begin
        ir_wren   = 1'b0;
        data_wren = 1'b0;
        pc_wren   = 1'b0;
        stall     = 1'b0;
        if (!reset) begin
            unique case (cur)
                S_LOAD: begin
                    stall   = waitrequest;
                    ir_wren = !waitrequest;
                end
                S_MEM: begin
                    stall     = waitrequest;
                    data_wren = !waitrequest && is_load_op(opcode);
                end
                S_EXEC: begin
                    stall   = md_hold;
                    pc_wren = !md_hold;
                end
                default: ;
            endcase
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-cycle vector table
// compared through an expected-result queue.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        waitrequest;
    logic [5:0]  instr_opcode;
    logic [5:0]  opcode;
    logic        md_busy;
    logic [31:0] next_pc;
    logic [2:0]  state;
    logic        ir_wren;
    logic        data_wren;
    logic        pc_wren;
    logic        stall;
    logic        active;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .waitrequest  (waitrequest),
        .instr_opcode (instr_opcode),
        .opcode       (opcode),
        .md_busy      (md_busy),
        .next_pc      (next_pc),
        .state        (state),
        .ir_wren      (ir_wren),
        .data_wren    (data_wren),
        .pc_wren      (pc_wren),
        .stall        (stall),
        .active       (active)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        wr;
        logic [5:0]  iop;
        logic [5:0]  op;
        logic        mdb;
        logic [31:0] npc;
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  exp_q[$];

    localparam logic [31:0] PC_A = 32'hBFC0_0004;

    // exp packs {state, ir_wren, data_wren, pc_wren, stall, active}
    function automatic vec_t mk(
        string n, logic rst, logic wr, logic [5:0] iop, logic [5:0] op,
        logic mdb, logic [31:0] npc, logic [2:0] st,
        logic ir, logic dw, logic pw, logic stl, logic act);
        vec_t v;
        v.name = n;
        v.rst  = rst;
        v.wr   = wr;
        v.iop  = iop;
        v.op   = op;
        v.mdb  = mdb;
        v.npc  = npc;
        v.exp  = {st, ir, dw, pw, stl, act};
        return v;
    endfunction

    task automatic chk(string n, int idx, logic [7:0] act,
                       logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got st=%0d ir=%b dw=%b pw=%b stl=%b act=%b want st=%0d ir=%b dw=%b pw=%b stl=%b act=%b",
                     n, idx, act[7:5], act[4], act[3], act[2],
                     act[1], act[0], exp[7:5], exp[4],
                     exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        reset        = 1'b1;
        waitrequest  = 1'b0;
        instr_opcode = 6'd0;
        opcode       = 6'd0;
        md_busy      = 1'b0;
        next_pc      = PC_A;

        // reset state, strobes held low even with a load opcode pending
        vecs.push_back(mk("rst", 1, 0, 35, 35, 0, PC_A, 0, 0, 0, 0, 0, 1));
        // ADDIU: 0,1,4
        vecs.push_back(mk("addiu_f", 0, 0, 9, 9, 0, PC_A, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("addiu_l", 0, 0, 9, 9, 0, PC_A, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk("addiu_e", 0, 0, 9, 9, 0, PC_A, 4, 0, 0, 1, 0, 1));
        // LW with 2 LOAD waits and 3 MEM waits
        vecs.push_back(mk("lw_f",  0, 1, 35, 9, 0, PC_A, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("lw_w1", 0, 1, 35, 9, 0, PC_A, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk("lw_w2", 0, 1, 35, 9, 0, PC_A, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk("lw_l",  0, 0, 35, 9, 0, PC_A, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk("lw_m1", 0, 1, 0, 35, 0, PC_A, 2, 0, 0, 0, 1, 1));
        vecs.push_back(mk("lw_m2", 0, 1, 0, 35, 0, PC_A, 2, 0, 0, 0, 1, 1));
        vecs.push_back(mk("lw_m3", 0, 1, 0, 35, 0, PC_A, 2, 0, 0, 0, 1, 1));
        vecs.push_back(mk("lw_m4", 0, 0, 0, 35, 0, PC_A, 2, 0, 1, 0, 0, 1));
        vecs.push_back(mk("lw_ld", 0, 1, 0, 35, 0, PC_A, 3, 0, 0, 0, 0, 1));
        vecs.push_back(mk("lw_e",  0, 1, 0, 35, 0, PC_A, 4, 0, 0, 1, 0, 1));
        // SW zero wait
        vecs.push_back(mk("sw_f", 0, 0, 43, 35, 0, PC_A, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("sw_l", 0, 0, 43, 35, 0, PC_A, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk("sw_m", 0, 0, 0, 43, 0, PC_A, 2, 0, 0, 0, 0, 1));
        vecs.push_back(mk("sw_e", 0, 0, 0, 43, 0, PC_A, 4, 0, 0, 1, 0, 1));
        // unknown opcode goes straight to EXEC
        vecs.push_back(mk("unk_f", 0, 0, 63, 0, 0, PC_A, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("unk_l", 0, 0, 63, 0, 0, PC_A, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk("unk_e", 0, 0, 63, 63, 0, PC_A, 4, 0, 0, 1, 0, 1));
        // LB and SH boundary opcodes
        vecs.push_back(mk("lb_f", 0, 0, 32, 0, 0, PC_A, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("lb_l", 0, 0, 32, 0, 0, PC_A, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk("lb_m", 0, 0, 0, 32, 0, PC_A, 2, 0, 1, 0, 0, 1));
        vecs.push_back(mk("lb_d", 0, 0, 0, 32, 0, PC_A, 3, 0, 0, 0, 0, 1));
        vecs.push_back(mk("lb_e", 0, 0, 0, 32, 0, PC_A, 4, 0, 0, 1, 0, 1));
        vecs.push_back(mk("op39_f", 0, 0, 39, 0, 0, PC_A, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("op39_l", 0, 0, 39, 0, 0, PC_A, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk("op39_e", 0, 0, 0, 39, 0, PC_A, 4, 0, 0, 1, 0, 1));
        vecs.push_back(mk("sh_f", 0, 0, 41, 0, 0, PC_A, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("sh_l", 0, 0, 41, 0, 0, PC_A, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk("sh_m", 0, 0, 0, 41, 0, PC_A, 2, 0, 0, 0, 0, 1));
        vecs.push_back(mk("sh_e", 0, 0, 0, 41, 0, PC_A, 4, 0, 0, 1, 0, 1));
        // DIVU with md_busy for 4 EXEC cycles
        vecs.push_back(mk("div_f", 0, 0, 0, 0, 0, PC_A, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("div_l", 0, 0, 0, 0, 0, PC_A, 1, 1, 0, 0, 0, 1));
`ifdef CPU_SEQ_MD_STALL_EN
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("div_h", 0, 1, 0, 0, 1, PC_A,
                              4, 0, 0, 0, 1, 1));
        vecs.push_back(mk("div_e", 0, 0, 0, 0, 0, PC_A, 4, 0, 0, 1, 0, 1));
`else
        vecs.push_back(mk("div_e", 0, 0, 0, 0, 1, PC_A, 4, 0, 0, 1, 0, 1));
`endif
        // reset beats strobes in LOAD and EXEC
        vecs.push_back(mk("rl_f", 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("rl_l", 1, 0, 9, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("re_f", 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("re_l", 0, 0, 9, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk("re_e", 1, 0, 9, 9, 0, 0, 4, 0, 0, 0, 0, 1));
        // reset during a MEM wait
        vecs.push_back(mk("rm_f", 0, 0, 35, 0, 0, PC_A, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("rm_l", 0, 0, 35, 0, 0, PC_A, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk("rm_w", 0, 1, 0, 35, 0, PC_A, 2, 0, 0, 0, 1, 1));
        vecs.push_back(mk("rm_r", 1, 1, 0, 35, 0, PC_A, 2, 0, 0, 0, 0, 1));
        // JR to 0 halts
        vecs.push_back(mk("jr_f", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("jr_l", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk("jr_e", 0, 0, 0, 0, 0, 0, 4, 0, 0, 1, 0, 1));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk("halt", 0, i[0], 35, 35, i[1], 0,
                              5, 0, 0, 0, 0, 0));
        vecs.push_back(mk("halt_r", 1, 0, 35, 35, 0, 0, 5, 0, 0, 0, 0, 0));
        vecs.push_back(mk("post_r", 0, 0, 9, 9, 0, PC_A, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("post_l", 0, 0, 9, 9, 0, PC_A, 1, 1, 0, 0, 0, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", -1,
            {state, ir_wren, data_wren, pc_wren, stall, active},
            {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            sb_t s;
            sb_t got;
            @(posedge clk);
            #1;
            reset        = vecs[i].rst;
            waitrequest  = vecs[i].wr;
            instr_opcode = vecs[i].iop;
            opcode       = vecs[i].op;
            md_busy      = vecs[i].mdb;
            next_pc      = vecs[i].npc;
            s.name = vecs[i].name;
            s.exp  = vecs[i].exp;
            exp_q.push_back(s);
            @(negedge clk);
            got = exp_q.pop_front();
            chk(got.name, i,
                {state, ir_wren, data_wren, pc_wren, stall, active},
                got.exp);
        end

        @(negedge clk);
        chk("wait_expired", -2,
            {state, ir_wren, data_wren, pc_wren, stall, active},
            {3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle state sequencer for the bus-based MIPS core. It owns the CPU state register consumed by the control decoder (FETCH/LOAD/MEM/LOAD_DATA/EXEC) and advances it using bus `waitrequest`, the fetched opcode, multiply/divide busy and the next-PC value. It generates the instruction-register, data-register and PC write strobes, and detects the halt condition (jump to address 0). It sits in `mips_cpu_bus` between the bus interface and the control decoder, replacing the ad-hoc state logic there.

## Interface
- No parameters.
- `clk`  in  1  core clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `waitrequest`  in  1  bus stall from memory
- `instr_opcode`  in  6  opcode field of the instruction word currently on `readdata` (valid in LOAD when `waitrequest`=0)
- `opcode`  in  6  opcode from the latched instruction register (valid in MEM/LOAD_DATA/EXEC)
- `md_busy`  in  1  multiply/divide unit still computing
- `next_pc`  in  32  PC value that EXEC will commit
- `state`  out  3  0 FETCH, 1 LOAD, 2 MEM, 3 LOAD_DATA, 4 EXEC, 5 HALT
- `ir_wren`  out  1  capture `readdata` into instruction register
- `data_wren`  out  1  capture `readdata` into load-data register
- `pc_wren`  out  1  commit `next_pc` to PC
- `stall`  out  1  current cycle is a wait/hold cycle
- `active`  out  1  high while running, low once halted

## Operation
- Reset values: `state`=FETCH, `active`=1, all strobes 0, `stall`=0. Reset mid-operation abandons the instruction. Next state is FETCH with no PC commit and no register writes.
- FETCH: one cycle. The decoder drives `read`. Always go to LOAD.
- LOAD: `read` is held. While `waitrequest`=1, stay in LOAD with `stall`=1.
  - On `waitrequest`=0: `ir_wren`=1.
  - Go to MEM if `instr_opcode` ∈ {32..38, 40, 41, 43} (loads, SB, SH, SW); otherwise go to EXEC.
- MEM: the decoder drives `read` or `write` and the ALU computes the address. While `waitrequest`=1, stay with `stall`=1.
  - On release: loads (`opcode` 32–38) assert `data_wren`=1 and go to LOAD_DATA. Stores go to EXEC.
- LOAD_DATA: one cycle. Go to EXEC.
- EXEC: the decoder performs writeback and branch/jump selection.
  - If EXEC may complete this cycle (see Configuration): `pc_wren`=1. Next state is HALT if `next_pc`==0, else FETCH.
- HALT: terminal state. `active`=0, all strobes 0, `state`=5. Only `reset` leaves HALT.
- The decoder treats state 5 as idle: no `read`, `write` or register writes.
- Strobes are combinational from the state register and inputs. `state` and `active` are registered.
- `waitrequest` is ignored in FETCH, LOAD_DATA, EXEC and HALT.
- Unknown opcodes take the non-memory path (LOAD→EXEC).

## Timing
- Zero-wait latency:
  - ALU, branch and jump: 3 cycles (FETCH, LOAD, EXEC).
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each `waitrequest`=1 cycle in LOAD or MEM adds exactly one cycle.
- Each `md_busy` hold cycle in EXEC adds exactly one cycle (macro enabled).
- `pc_wren` is high in exactly one cycle per instruction. `ir_wren` is high in exactly one cycle per instruction. `data_wren` is high in exactly one cycle per load.
- `active` falls on the clock edge that enters HALT. It is first observed low in the cycle after EXEC commits PC 0.
- `reset` asserted in the same cycle as a strobe condition wins: the next state is FETCH.

## Configuration
- `CPU_SEQ_MD_STALL_EN` defined:
  - EXEC holds while `md_busy`=1, with `stall`=1 and `pc_wren`=0. The decoder's `hi_wren`/`lo_wren` pulse repeats during the hold.
  - EXEC also holds for MFHI/MFLO (`opcode`=0) while `md_busy`=1.
  - EXEC completes on the first cycle `md_busy`=0.
- `CPU_SEQ_MD_STALL_EN` undefined: `md_busy` is ignored and EXEC always completes in one cycle. This is correct for the combinational multiplier/divider.

## Structure
- Shared package `mips_pkg` holds:
  - State enum typedef `cpu_state_t` (3-bit, values above), used by both the sequencer and the control decoder.
  - Opcode constants `OP_LB`…`OP_LWR`, `OP_SB`, `OP_SH`, `OP_SW`.
  - Function constants `FN_MFHI`, `FN_MFLO`.
- No sub-module: a single registered FSM plus combinational strobe and next-state logic.

## Test plan
- Reset, then ADDIU (`instr_opcode`=9) with `waitrequest`=0 and `next_pc`=0xBFC00004 → states 0,1,4,0. `ir_wren` high in LOAD, `pc_wren` high in EXEC, `active`=1.
- LW (35) with `waitrequest`=1 for 2 cycles in LOAD and 3 cycles in MEM → states 0,1,1,1,2,2,2,2,3,4. `stall` high 5 cycles, one `data_wren` in the last MEM cycle.
- SW (43) with zero waits → states 0,1,2,4,0. `data_wren` never asserted.
- JR with `next_pc`=0 in EXEC → next state 5, `active`=0. State stays 5 for 10 cycles regardless of `waitrequest`. `reset` returns it to state 0 with `active`=1.
- DIVU with macro defined, `md_busy`=1 for 4 EXEC cycles → EXEC lasts 5 cycles, single `pc_wren` in the fifth. With the macro undefined, EXEC lasts 1 cycle.
- `reset` pulsed in MEM during `waitrequest`=1 → next state FETCH, no `pc_wren`/`data_wren` issued.
